// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter that lets N requesters share one load/set/clear register.
// Each granted requester gets exactly one strobe cycle, then must release before the next grant.
module reg_access_arbiter #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [2*N-1:0]   op,
    input  logic [W*N-1:0]   wdata,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     ack,
    output logic             reg_load,
    output logic             reg_set,
    output logic             reg_clr,
    output logic [W-1:0]     reg_d,
    output logic             busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   win_sel;
    logic [PW-1:0]   ptr_after_win;
    logic [1:0]      cap_op;
    logic [W-1:0]    cap_data;
    logic [N-1:0]    gnt_q;
    logic            any_req;

    // First requesting index at or after the pointer, wrapping N-1 -> 0.
    always_comb begin : rr_search
        int idx;
        any_req = 1'b0;
        win_sel = '0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                win_sel = PW'(idx);
            end
        end
        ptr_after_win = (win_sel == PW'(N - 1)) ? '0 : win_sel + PW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            winner   <= '0;
            gnt_q    <= '0;
            cap_op   <= '0;
            cap_data <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                winner        <= win_sel;
                gnt_q         <= '0;
                gnt_q[win_sel] <= 1'b1;
                cap_op        <= op[2*win_sel +: 2];
                cap_data      <= wdata[W*win_sel +: W];
                rr_ptr        <= ptr_after_win;
            end else if (state == RELEASE && !req[winner]) begin
                gnt_q <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = RELEASE;
            RELEASE: if (!req[winner]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are decoded only from the captured op, so late op/wdata changes cannot leak through.
    always_comb begin
        gnt      = gnt_q;
        ack      = '0;
        reg_load = 1'b0;
        reg_set  = 1'b0;
        reg_clr  = 1'b0;
        reg_d    = '0;
        busy     = (state != IDLE);
        if (state == ISSUE) begin
            ack = gnt_q;
            case (cap_op)
                2'b01: begin
                    reg_load = 1'b1;
                    reg_d    = cap_data;
                end
                2'b10:   reg_set = 1'b1;
                2'b11:   reg_clr = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
